prog_sequencer: RTL and testbench
=================================

# prog_sequencer

- Drives the core's program-launch interface.
- Issues a start pulse plus start address for each of the three benchmark programs in order: PRODUCT, STRING MATCH, CLOSEST PAIR.
- Waits for the core's `done` (halt) indication after each launch and records per-program cycle counts.
- Flags programs that exceed a cycle budget.
- Sits between the testbench/top level and the core: the PC consumes `core_start`/`start_pc`; the halt logic produces `done`.

## Interface

Parameters:
- NUM_PROGS, 3, number of programs launched per run (max 4)
- START_CYCLES, 2, cycles `core_start` is held high per launch (≥1)
- CNT_W, 16, width of cycle counter
- TIMEOUT, 4000, cycle budget per program (1 ≤ TIMEOUT ≤ 2^CNT_W−1)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- go  in  1  request a full run; sampled only in IDLE or FINISH
- done  in  1  core halted; sampled only in RUN
- core_start  out  1  launch pulse to PC/core
- start_pc  out  8  start address of current program, valid while core_start high
- prog_id  out  2  index of current/last program
- busy  out  1  high in LAUNCH, RUN, GAP
- done_valid  out  1  one-cycle pulse: done_cycles/done_prog valid
- done_prog  out  2  program index for done_cycles
- done_cycles  out  CNT_W  cycles consumed by that program
- timeout  out  NUM_PROGS  sticky per-program timeout bits
- all_done  out  1  high in FINISH

## Operation

- Reset value of all outputs and state registers is 0; the state machine resets to IDLE.
- The reset path is asynchronous and clock-independent; it is not derived from the core reset.
- States: IDLE, LAUNCH, RUN, GAP, FINISH.
- IDLE or FINISH, go=1:
  - prog_id←0, timeout←0, all_done←0.
  - Next state LAUNCH.
- LAUNCH:
  - core_start=1, start_pc=PROG_BASE[prog_id].
  - Stays for exactly START_CYCLES cycles, then RUN with run_cnt←0.
  - done ignored.
- RUN: core_start=0; run_cnt counts cycles. Each cycle, one of:
  - done=1: done_cycles←run_cnt+1, done_prog←prog_id, done_valid pulses; next state GAP.
  - done=0 and run_cnt+1==TIMEOUT: timeout[prog_id]←1, done_cycles←TIMEOUT, done_valid pulses; next state GAP.
  - otherwise: run_cnt←run_cnt+1.
- GAP (1 cycle, core_start=0):
  - prog_id==NUM_PROGS−1: next state FINISH.
  - otherwise: prog_id←prog_id+1, next state LAUNCH.
- FINISH:
  - all_done=1, busy=0.
  - Results (done_cycles, done_prog, timeout) hold until the next go.
- go while busy: ignored (no queuing).
- done outside RUN: ignored.
- done and timeout in the same cycle: done wins; the timeout bit is not set.
- run_cnt never wraps, because TIMEOUT bounds it.
- reset mid-run: immediate return to IDLE; partial results are discarded; core_start drops asynchronously.

## Timing

- All outputs are registered.
- go high at edge k (in IDLE): core_start high for edges k+1 … k+START_CYCLES.
- First RUN cycle follows the last core_start cycle.
- done high at the n-th RUN edge: done_valid and done_cycles=n are visible the cycle after that edge.
- Next core_start rises 2 cycles after the done edge (GAP, then LAUNCH).
- all_done rises 2 cycles after the last program's done edge.

## Structure

- Shared package `definitions` gains:
  - seq_state_t enum (IDLE, LAUNCH, RUN, GAP, FINISH);
  - PROG_BASE array of 8-bit start addresses {0, 25, 44} (PRODUCT, STRING MATCH, CLOSEST PAIR);
  - NUM_PROGS_DEFAULT constant.
- The PC loads start_pc on core_start instead of keeping its own internal state counter.
- One natural sub-module: `cycle_counter` (CNT_W-bit, synchronous clear, enable, terminal-match output for TIMEOUT).

## Test plan

- Reset then go=1 for 1 cycle, START_CYCLES=2 → core_start high for exactly 2 cycles; start_pc=0; prog_id=0; busy=1.
- done asserted on 7th RUN cycle → done_valid pulse, done_prog=0, done_cycles=7; core_start rises 2 cycles later with start_pc=25.
- All three programs halt after 5/9/3 cycles → done_cycles sequence 5, 9, 3; start_pc sequence 0, 25, 44; all_done=1; timeout=3'b000.
- TIMEOUT=10, program 1 never raises done → timeout=3'b010, done_cycles=10 for prog 1; program 2 still launches at 44.
- done held high during LAUNCH, plus a go pulse mid-RUN → neither affects state; done_cycles counts only from RUN entry.
- reset asserted mid-RUN of program 2 (async, between edges) → outputs are 0 before the next edge; state IDLE; new go restarts at start_pc=0.

Source files
------------

// File: rtl/prog_sequencer_pkg.sv
// Shared types and constants for the benchmark program-launch sequencer.
package prog_sequencer_pkg;

  typedef enum logic [2:0] {IDLE, LAUNCH, RUN, GAP, FINISH} seq_state_t;

  localparam int NUM_PROGS_DEFAULT = 3;

  // PRODUCT, STRING MATCH, CLOSEST PAIR; the fourth slot is unused
  localparam logic [7:0] PROG_BASE [4] = '{8'd0, 8'd25, 8'd44, 8'd0};

endpackage

// File: rtl/prog_sequencer_cycle_counter.sv
// Up-counter with synchronous clear and a terminal-match flag; saturates at the terminal value.
module cycle_counter #(
  parameter int CNT_W = 16,
  parameter logic [CNT_W-1:0] TERMINAL = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             match
);

  assign match = (count == TERMINAL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (enable && !match)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/prog_sequencer.sv
// Launches each benchmark program on the core in turn, times it until halt,
// and flags programs that run past the cycle budget.
//   state  | meaning
//   IDLE   | waiting for go after reset
//   LAUNCH | core_start high, start_pc presented
//   RUN    | core executing, counting cycles until done or budget
//   GAP    | one-cycle spacer before next launch or finish
//   FINISH | all programs complete, results held until next go
module prog_sequencer
  import prog_sequencer_pkg::*;
#(
  parameter int NUM_PROGS    = NUM_PROGS_DEFAULT,
  parameter int START_CYCLES = 2,
  parameter int CNT_W        = 16,
  parameter int TIMEOUT      = 4000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 go,
  input  logic                 done,
  output logic                 core_start,
  output logic [7:0]           start_pc,
  output logic [1:0]           prog_id,
  output logic                 busy,
  output logic                 done_valid,
  output logic [1:0]           done_prog,
  output logic [CNT_W-1:0]     done_cycles,
  output logic [NUM_PROGS-1:0] timeout,
  output logic                 all_done
);

  localparam int LW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam logic [LW-1:0]    LAUNCH_LAST = LW'(START_CYCLES - 1);
  localparam logic [1:0]       LAST_ID     = 2'(NUM_PROGS - 1);
  localparam logic [CNT_W-1:0] RUN_LAST    = CNT_W'(TIMEOUT - 1);

  seq_state_t      state;
  logic [LW-1:0]   launch_cnt;
  logic [CNT_W-1:0] run_cnt;
  logic            run_last;

  // Held clear outside RUN so every program starts counting from zero
  cycle_counter #(
    .CNT_W    (CNT_W),
    .TERMINAL (RUN_LAST)
  ) u_run_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (state != RUN),
    .enable (state == RUN),
    .count  (run_cnt),
    .match  (run_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      launch_cnt  <= '0;
      core_start  <= 1'b0;
      start_pc    <= '0;
      prog_id     <= '0;
      busy        <= 1'b0;
      done_valid  <= 1'b0;
      done_prog   <= '0;
      done_cycles <= '0;
      timeout     <= '0;
      all_done    <= 1'b0;
    end else begin
      done_valid <= 1'b0;
      case (state)
        IDLE, FINISH: begin
          if (go) begin
            prog_id    <= '0;
            timeout    <= '0;
            all_done   <= 1'b0;
            busy       <= 1'b1;
            core_start <= 1'b1;
            start_pc   <= PROG_BASE[0];
            launch_cnt <= '0;
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (launch_cnt == LAUNCH_LAST) begin
            core_start <= 1'b0;
            state      <= RUN;
          end else begin
            launch_cnt <= launch_cnt + 1'b1;
          end
        end
        RUN: begin
          // done has priority over an expiring budget in the same cycle
          if (done) begin
            done_cycles <= run_cnt + 1'b1;
            done_prog   <= prog_id;
            done_valid  <= 1'b1;
            state       <= GAP;
          end else if (run_last) begin
            timeout[prog_id] <= 1'b1;
            done_cycles      <= CNT_W'(TIMEOUT);
            done_prog        <= prog_id;
            done_valid       <= 1'b1;
            state            <= GAP;
          end
        end
        GAP: begin
          if (prog_id == LAST_ID) begin
            busy     <= 1'b0;
            all_done <= 1'b1;
            state    <= FINISH;
          end else begin
            prog_id    <= prog_id + 2'd1;
            start_pc   <= PROG_BASE[prog_id + 2'd1];
            core_start <= 1'b1;
            launch_cnt <= '0;
            state      <= LAUNCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: drives go/done like a core would,
// scoreboards every done_valid report against the expected program/cycle pair.
module tb_prog_sequencer;

  localparam int TO = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        go = 1'b0;
  logic        done = 1'b0;
  logic        core_start;
  logic [7:0]  start_pc;
  logic [1:0]  prog_id;
  logic        busy;
  logic        done_valid;
  logic [1:0]  done_prog;
  logic [15:0] done_cycles;
  logic [2:0]  timeout;
  logic        all_done;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];
  int base[3] = '{0, 25, 44};

  prog_sequencer #(
    .NUM_PROGS    (3),
    .START_CYCLES (2),
    .CNT_W        (16),
    .TIMEOUT      (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .go          (go),
    .done        (done),
    .core_start  (core_start),
    .start_pc    (start_pc),
    .prog_id     (prog_id),
    .busy        (busy),
    .done_valid  (done_valid),
    .done_prog   (done_prog),
    .done_cycles (done_cycles),
    .timeout     (timeout),
    .all_done    (all_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard: every done_valid pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (done_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done_valid", 32'(exp_q.size()), 32'd1);
      end else begin
        int e;
        e = exp_q.pop_front();
        check("done_prog", 32'(done_prog), 32'(e >> 16));
        check("done_cycles", 32'(done_cycles), 32'(e & 32'hffff));
      end
    end
  end

  // lat = RUN cycle on which done is raised; 0 means the program never halts.
  task automatic run_seq(input int l0, input int l1, input int l2,
                         input bit done_in_launch, input bit mid_go, input int rst_prog);
    int lat[3];
    int w;
    int len;
    int n;
    int last_n;
    logic [2:0] exp_to;
    lat    = '{l0, l1, l2};
    exp_to = 3'b000;
    last_n = 0;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    for (int i = 0; i < 3; i++) begin
      w = 0;
      while (core_start !== 1'b1 && w < 20) begin
        @(negedge clk);
        w++;
      end
      check("launch_wait", 32'(w), (i == 0) ? 32'd0 : 32'd1);
      if (core_start !== 1'b1) return;
      check("start_pc", 32'(start_pc), 32'(base[i]));
      check("prog_id", 32'(prog_id), 32'(i));
      check("busy_launch", 32'(busy), 32'd1);
      if (i == 0) begin
        check("timeout_cleared", 32'(timeout), 32'd0);
        check("all_done_cleared", 32'(all_done), 32'd0);
      end
      if (done_in_launch) done = 1'b1;
      len = 0;
      while (core_start === 1'b1 && len < 20) begin
        @(negedge clk);
        len++;
      end
      done = 1'b0;
      check("core_start_len", 32'(len), 32'd2);
      if (i == rst_prog) begin
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_core_start", 32'(core_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_prog_id", 32'(prog_id), 32'd0);
        check("rst_done_cycles", 32'(done_cycles), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        return;
      end
      n = (lat[i] == 0) ? TO : lat[i];
      if (lat[i] == 0) exp_to[i] = 1'b1;
      last_n = n;
      exp_q.push_back((i << 16) | n);
      for (int c = 1; c < n; c++) begin
        @(negedge clk);
        go = mid_go && (c == 2);
      end
      go = 1'b0;
      if (lat[i] != 0) done = 1'b1;
      @(negedge clk);
      done = 1'b0;
    end
    w = 0;
    while (all_done !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("finish_wait", 32'(w), 32'd1);
    check("all_done", 32'(all_done), 32'd1);
    check("busy_finish", 32'(busy), 32'd0);
    check("timeout_bits", 32'(timeout), 32'(exp_to));
    check("final_cycles", 32'(done_cycles), 32'(last_n));
    check("final_prog", 32'(done_prog), 32'd2);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("reset_core_start", 32'(core_start), 32'd0);
    check("reset_start_pc", 32'(start_pc), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done_valid", 32'(done_valid), 32'd0);
    check("reset_done_cycles", 32'(done_cycles), 32'd0);
    check("reset_timeout", 32'(timeout), 32'd0);
    check("reset_all_done", 32'(all_done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_seq(5, 9, 3, 1'b0, 1'b0, -1);
    run_seq(4, 0, 10, 1'b0, 1'b0, -1);
    run_seq(7, 4, 6, 1'b1, 1'b1, -1);
    run_seq(3, 5, 8, 1'b0, 1'b0, 2);
    run_seq(1, 2, 3, 1'b0, 1'b0, -1);
    @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
